seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl.sv | 179 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller; display data is double-buffered and swapped only at frame boundaries.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_ctrl #(
    parameter int unsigned DIGITS    = 6,
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    input  logic [4*DIGITS-1:0] disp_num,
    input  logic [DIGITS-1:0]   dp_in,
    output logic [7:0]          SEGMENT,
    output logic [DIGITS-1:0]   AN,
    output logic [2:0]          scan_idx,
    output logic                frame_done
);
    localparam int unsigned CNT_MAX    = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int unsigned CW         = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
    localparam logic [2:0]    IDX_LAST   = 3'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [2:0]          idx_n;
    logic                frame_end;
    logic [4*DIGITS-1:0] act_num, act_num_n, pend_num;
    logic [DIGITS-1:0]   act_dp, act_dp_n, pend_dp;
    logic                pend;
    logic [7:0]          seg_n;
    logic [DIGITS-1:0]   an_n;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        hex7 = 7'h00;
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            4'hF: hex7 = 7'h71;
            default: hex7 = 7'h00;
        endcase
    endfunction

    // Scan sequencing: blank gap, then dwell on one digit; en low parks in IDLE.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = scan_idx;
        frame_end = 1'b0;
        if (!en) begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_n   = '0;
                    state_n = (BLANK_CYC == 0) ? SHOW : BLANK;
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        cnt_n   = '0;
                        state_n = SHOW;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        cnt_n     = '0;
                        frame_end = (scan_idx == IDX_LAST);
                        idx_n     = (scan_idx == IDX_LAST) ? 3'd0 : scan_idx + 3'd1;
                        state_n   = (BLANK_CYC == 0) ? SHOW : BLANK;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Active data only changes at the frame boundary; a coincident load bypasses pending.
    always_comb begin
        act_num_n = act_num;
        act_dp_n  = act_dp;
        if (frame_end) begin
            if (load) begin
                act_num_n = disp_num;
                act_dp_n  = dp_in;
            end else if (pend) begin
                act_num_n = pend_num;
                act_dp_n  = pend_dp;
            end
        end
    end

    // Outputs are decoded from next-cycle state/data so AN and SEGMENT register together.
    always_comb begin
`ifdef SEG7_LZB_EN
        logic              any_nz;
        logic [DIGITS-1:0] lead_zero;
        any_nz    = 1'b0;
        lead_zero = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            any_nz       = any_nz | (|act_num_n[4*i +: 4]);
            lead_zero[i] = ~any_nz;
        end
`endif
        seg_n = 8'h00;
        an_n  = '0;
        if (state_n == SHOW) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx_n == 3'(i)) begin
                    an_n[i] = 1'b1;
                    seg_n   = {act_dp_n[i], hex7(act_num_n[4*i +: 4])};
`ifdef SEG7_LZB_EN
                    if (i > 0 && lead_zero[i]) seg_n[6:0] = 7'h00;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            scan_idx <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            scan_idx <= idx_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            SEGMENT    <= 8'h00;
            AN         <= '0;
            frame_done <= 1'b0;
            act_num    <= '0;
            act_dp     <= '0;
            pend_num   <= '0;
            pend_dp    <= '0;
            pend       <= 1'b0;
        end else begin
            SEGMENT    <= seg_n;
            AN         <= an_n;
            frame_done <= frame_end;
            act_num    <= act_num_n;
            act_dp     <= act_dp_n;
            if (frame_end) begin
                pend <= 1'b0;
            end else if (load) begin
                pend_num <= disp_num;
                pend_dp  <= dp_in;
                pend     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: 4-digit scan instance plus a 1-digit no-blank instance.
module tb_seg7_scan_ctrl;
    logic        clk;
    logic        rst, en, load;
    logic [15:0] disp_num;
    logic [3:0]  dp_in;
    logic [7:0]  segment;
    logic [3:0]  an;
    logic [2:0]  scan_idx;
    logic        frame_done;

    logic        load1;
    logic [3:0]  disp1;
    logic [0:0]  dp1;
    logic [7:0]  seg1;
    logic [0:0]  an1;
    logic [2:0]  idx1;
    logic        fd1;

    int errors = 0;
    int checks = 0;

`ifdef SEG7_LZB_EN
    localparam logic [31:0] Z_EXP  = 32'h0000003F;
    localparam logic [31:0] N50EXP = 32'h00006D3F;
`else
    localparam logic [31:0] Z_EXP  = 32'h3F3F3F3F;
    localparam logic [31:0] N50EXP = 32'h3F3F6D3F;
`endif

    seg7_scan_ctrl #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .disp_num(disp_num), .dp_in(dp_in),
        .SEGMENT(segment), .AN(an), .scan_idx(scan_idx), .frame_done(frame_done)
    );

    seg7_scan_ctrl #(.DIGITS(1), .SCAN_DIV(4), .BLANK_CYC(0)) dut1 (
        .clk(clk), .rst(rst), .en(en), .load(load1), .disp_num(disp1), .dp_in(dp1),
        .SEGMENT(seg1), .AN(an1), .scan_idx(idx1), .frame_done(fd1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walks one 20-cycle frame starting in its leading blank cycle; exp holds {d3,d2,d1,d0} segments.
    // la/lb: digit at whose first lit edge a load is applied (4 = at the frame boundary edge).
    task automatic check_frame(input string tag, input logic [31:0] exp,
                               input int la, input logic [15:0] va, input logic [3:0] pa,
                               input int lb, input logic [15:0] vb, input logic [3:0] pb);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 0 && d == la) begin load = 1'b1; disp_num = va; dp_in = pa; end
                if (c == 0 && d == lb) begin load = 1'b1; disp_num = vb; dp_in = pb; end
                step();
                load = 1'b0;
                chk($sformatf("%s_an_d%0d_c%0d", tag, d, c), 32'(an), 32'(1) << d);
                chk($sformatf("%s_seg_d%0d_c%0d", tag, d, c), 32'(segment), 32'(exp[8*d +: 8]));
                chk($sformatf("%s_idx_d%0d_c%0d", tag, d, c), 32'(scan_idx), 32'(d));
                chk($sformatf("%s_fd_d%0d_c%0d", tag, d, c), 32'(frame_done), 32'(0));
            end
            if (d == 3 && la == 4) begin load = 1'b1; disp_num = va; dp_in = pa; end
            step();
            load = 1'b0;
            chk($sformatf("%s_blank_an_d%0d", tag, d), 32'(an), 32'(0));
            chk($sformatf("%s_blank_seg_d%0d", tag, d), 32'(segment), 32'(0));
            chk($sformatf("%s_blank_fd_d%0d", tag, d), 32'(frame_done), 32'(d == 3));
        end
    endtask

    initial begin
        logic found;
        rst = 1'b1; en = 1'b0; load = 1'b0; disp_num = '0; dp_in = '0;
        load1 = 1'b0; disp1 = '0; dp1 = '0;
        step();
        step();
        chk("rst_an", 32'(an), 32'(0));
        chk("rst_seg", 32'(segment), 32'(0));
        chk("rst_idx", 32'(scan_idx), 32'(0));
        chk("rst_fd", 32'(frame_done), 32'(0));
        chk("rst_an1", 32'(an1), 32'(0));
        chk("rst_seg1", 32'(seg1), 32'(0));
        chk("rst_fd1", 32'(fd1), 32'(0));

        rst = 1'b0;
        step();
        load = 1'b1; disp_num = 16'h12AF; dp_in = 4'b0010;
        step();
        load = 1'b0;
        chk("idle_an", 32'(an), 32'(0));
        chk("idle_seg", 32'(segment), 32'(0));

        en = 1'b1;
        step();
        chk("first_blank_an", 32'(an), 32'(0));
        check_frame("f0", Z_EXP, -1, '0, '0, -1, '0, '0);
        check_frame("f1", 32'h065BF771, 1, 16'h1111, 4'b1001, -1, '0, '0);
        check_frame("f2", 32'h86060686, 2, 16'h2222, 4'b0000, -1, '0, '0);
        check_frame("f3", 32'h5B5B5B5B, 0, 16'h3333, 4'b0000, 2, 16'h4444, 4'b0000);
        check_frame("f4", 32'h66666666, 4, 16'h5555, 4'b0000, -1, '0, '0);
        check_frame("f5", 32'h6D6D6D6D, -1, '0, '0, -1, '0, '0);
        check_frame("f6", 32'h6D6D6D6D, -1, '0, '0, -1, '0, '0);

        // Drop en while digit 2 is lit.
        for (int k = 0; k < 12; k++) step();
        chk("pre_stop_an", 32'(an), 32'(4'b0100));
        chk("pre_stop_idx", 32'(scan_idx), 32'(2));
        en = 1'b0;
        step();
        chk("stop_an", 32'(an), 32'(0));
        chk("stop_seg", 32'(segment), 32'(0));
        chk("stop_idx", 32'(scan_idx), 32'(0));
        chk("stop_fd", 32'(frame_done), 32'(0));
        step();
        step();
        chk("stop_hold_an", 32'(an), 32'(0));
        en = 1'b1;
        step();
        chk("restart_blank_an", 32'(an), 32'(0));
        check_frame("f8", 32'h6D6D6D6D, -1, '0, '0, -1, '0, '0);

        // Reset mid-SHOW, with a coincident load that must be ignored.
        step();
        chk("pre_rst_an", 32'(an), 32'(1));
        rst = 1'b1; load = 1'b1; disp_num = 16'h7777; dp_in = 4'hF;
        step();
        rst = 1'b0; load = 1'b0;
        chk("mid_rst_an", 32'(an), 32'(0));
        chk("mid_rst_seg", 32'(segment), 32'(0));
        chk("mid_rst_idx", 32'(scan_idx), 32'(0));
        chk("mid_rst_fd", 32'(frame_done), 32'(0));
        step();
        check_frame("f9", Z_EXP, -1, '0, '0, -1, '0, '0);
        check_frame("f10", Z_EXP, 1, 16'h0050, 4'b0000, -1, '0, '0);
        check_frame("f11", N50EXP, -1, '0, '0, -1, '0, '0);

        // Single-digit instance without blank gap.
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            step();
            if (fd1) found = 1'b1;
        end
        chk("u1_fd_seen", 32'(found), 32'(1));
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("u1_an_%0d", k), 32'(an1), 32'(1));
            chk($sformatf("u1_seg_%0d", k), 32'(seg1), 32'(8'h3F));
            chk($sformatf("u1_idx_%0d", k), 32'(idx1), 32'(0));
            chk($sformatf("u1_fd_%0d", k), 32'(fd1), 32'(k % 4 == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
